// File: rtl/register_file_if.sv
// Register-file access bundle: one write port and two read ports, plus status outputs.
// The operand stage uses the master modport; the register file uses the slave modport.
interface register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              i_WE;
   logic [ADDR_W-1:0] i_RD;
   logic [ADDR_W-1:0] i_RS1;
   logic [ADDR_W-1:0] i_RS2;
   logic [DATA_W-1:0] i_REG_IN;
   logic [DATA_W-1:0] o_REG_OUT1;
   logic [DATA_W-1:0] o_REG_OUT2;
   logic              o_READY;
   logic [31:0]       o_WR_CNT;

   modport master (
      output i_WE, i_RD, i_RS1, i_RS2, i_REG_IN,
      input  o_REG_OUT1, o_REG_OUT2, o_READY, o_WR_CNT
   );

   modport slave (
      input  i_WE, i_RD, i_RS1, i_RS2, i_REG_IN,
      output o_REG_OUT1, o_REG_OUT2, o_READY, o_WR_CNT
   );
endinterface

// File: rtl/register_file.sv
// 2R1W register file with x0 hardwired to zero, optional write-to-read forwarding,
// and a post-reset CLEAR sequence that zeroes x1..xN one register per clock.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input logic            iCLK,
   input logic            iRST_N,
   register_file_if.slave rf
);
   localparam int                NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

   typedef enum logic {CLEAR, RUN} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic [31:0]       wr_cnt_q, wr_cnt_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem [NUM_REGS];

   logic              run;
   logic              commit;

   assign run    = (state_q == RUN);
   assign commit = run && rf.i_WE && (rf.i_RD != ZERO_IDX);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      wr_cnt_d  = wr_cnt_q;
      mem_we    = 1'b0;
      mem_addr  = rf.i_RD;
      mem_wdata = rf.i_REG_IN;
      unique case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_idx_q;
            mem_wdata = '0;
            clr_idx_d = clr_idx_q + ONE_IDX;
            if (clr_idx_q == LAST_IDX) state_d = RUN;
         end
         RUN: begin
            mem_we = commit;
            if (commit) wr_cnt_d = wr_cnt_q + 32'd1;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= CLEAR;
         clr_idx_q <= ONE_IDX;
         wr_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   // NOTE: the array has no reset on purpose; the CLEAR sequence zeroes it, which keeps
   // it mappable to plain RAM/flops without a reset tree.
   always_ff @(posedge iCLK) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // x0 and the whole CLEAR phase read zero; forwarding only ever applies in RUN.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] rs);
      logic [DATA_W-1:0] val;
      val = '0;
      if (run && (rs != ZERO_IDX)) begin
         if ((BYPASS != 0) && rf.i_WE && (rf.i_RD == rs)) val = rf.i_REG_IN;
         else                                             val = mem[rs];
      end
      return val;
   endfunction

   always_comb begin
      rf.o_REG_OUT1 = read_port(rf.i_RS1);
      rf.o_REG_OUT2 = read_port(rf.i_RS2);
   end

   assign rf.o_READY  = run;
   assign rf.o_WR_CNT = wr_cnt_q;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance driven in lockstep and
// compared against a behavioural model (edge counter + register array + write counter).
module tb_register_file;
   localparam int DW = 32;
   localparam int AW = 5;

   logic iclk;
   logic irst_n;

   register_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf_b ();
   register_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf_n ();

   register_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
      .iCLK(iclk), .iRST_N(irst_n), .rf(rf_b.slave)
   );
   register_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nob (
      .iCLK(iclk), .iRST_N(irst_n), .rf(rf_n.slave)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   int errors = 0;
   int checks = 0;

   // Current stimulus, mirrored onto both interfaces.
   logic          cur_we;
   logic [AW-1:0] cur_rd, cur_rs1, cur_rs2;
   logic [DW-1:0] cur_din;

   // Behavioural model.
   logic [DW-1:0] m_regs [32];
   int            m_edges;
   logic [31:0]   m_cnt;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [DW-1:0] din;
      logic [DW-1:0] b1;
      logic [DW-1:0] b2;
      logic [DW-1:0] n1;
      logic [DW-1:0] n2;
      logic [31:0]   cnt;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [DW-1:0] din);
      cur_we = we; cur_rd = rd; cur_rs1 = rs1; cur_rs2 = rs2; cur_din = din;
      rf_b.i_WE = we; rf_b.i_RD = rd; rf_b.i_RS1 = rs1; rf_b.i_RS2 = rs2; rf_b.i_REG_IN = din;
      rf_n.i_WE = we; rf_n.i_RD = rd; rf_n.i_RS1 = rs1; rf_n.i_RS2 = rs2; rf_n.i_REG_IN = din;
   endtask

   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] rs, input bit byp);
      if (m_edges < 31 || rs == 0) return '0;
      if (byp && cur_we && cur_rd == rs) return cur_din;
      return m_regs[rs];
   endfunction

   // Model reaction to one rising edge with reset deasserted.
   task automatic model_edge();
      if (m_edges < 31) begin
         m_regs[m_edges + 1] = '0;
         m_edges++;
      end else if (cur_we && cur_rd != 0) begin
         m_regs[cur_rd] = cur_din;
         m_cnt++;
      end
   endtask

   task automatic model_reset();
      m_edges = 0;
      m_cnt   = '0;
   endtask

   task automatic cycle();
      @(posedge iclk);
      if (irst_n) model_edge();
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_out1_byp"}, rf_b.o_REG_OUT1, exp_read(cur_rs1, 1'b1));
      check({tag, "_out2_byp"}, rf_b.o_REG_OUT2, exp_read(cur_rs2, 1'b1));
      check({tag, "_out1_nob"}, rf_n.o_REG_OUT1, exp_read(cur_rs1, 1'b0));
      check({tag, "_out2_nob"}, rf_n.o_REG_OUT2, exp_read(cur_rs2, 1'b0));
      check({tag, "_cnt_byp"},  rf_b.o_WR_CNT, m_cnt);
      check({tag, "_cnt_nob"},  rf_n.o_WR_CNT, m_cnt);
   endtask

   task automatic check_ready(input string tag, input logic exp);
      check({tag, "_ready_byp"}, {31'd0, rf_b.o_READY}, {31'd0, exp});
      check({tag, "_ready_nob"}, {31'd0, rf_n.o_READY}, {31'd0, exp});
   endtask

   initial begin
      tbl[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'd0};
      tbl[1] = '{1'b0, 5'd0,  5'd5,  5'd0,  32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'd1};
      tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd5,  32'h12345678, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'd1};
      tbl[3] = '{1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd1};
      tbl[4] = '{1'b1, 5'd7,  5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 32'd1};
      tbl[5] = '{1'b0, 5'd0,  5'd7,  5'd7,  32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd2};
      tbl[6] = '{1'b1, 5'd31, 5'd31, 5'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'd2};
      tbl[7] = '{1'b1, 5'd5,  5'd31, 5'd5,  32'h1, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'd3};
      tbl[8] = '{1'b0, 5'd0,  5'd5,  5'd31, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'd4};

      for (int i = 0; i < 32; i++) m_regs[i] = 'x;
      model_reset();
      irst_n = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      @(posedge iclk);
      #1;
      irst_n = 1'b1;
      #1;
      check_ready("pre_edge", 1'b0);

      // Post-reset clear: READY low for edges 1..30, high after edge 31.
      for (int n = 1; n <= 31; n++) begin
         cycle();
         check_ready($sformatf("clr_edge%0d", n), (n >= 31));
      end
      for (int r = 0; r < 32; r++) begin
         drive(1'b0, '0, r[AW-1:0], 5'(31 - r), '0);
         #1;
         check($sformatf("zero_x%0d", r), rf_b.o_REG_OUT1, 32'h0);
         check($sformatf("zero_x%0d_nob", 31 - r), rf_n.o_REG_OUT2, 32'h0);
      end

      // Directed vectors, each checked before its edge, also tracked by the model.
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].we, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].din);
         #1;
         check($sformatf("vec%0d_out1_byp", i), rf_b.o_REG_OUT1, tbl[i].b1);
         check($sformatf("vec%0d_out2_byp", i), rf_b.o_REG_OUT2, tbl[i].b2);
         check($sformatf("vec%0d_out1_nob", i), rf_n.o_REG_OUT1, tbl[i].n1);
         check($sformatf("vec%0d_out2_nob", i), rf_n.o_REG_OUT2, tbl[i].n2);
         check($sformatf("vec%0d_cnt", i),      rf_b.o_WR_CNT,   tbl[i].cnt);
         check($sformatf("vec%0d_cnt_nob", i),  rf_n.o_WR_CNT,   tbl[i].cnt);
         cycle();
      end

      // Randomised traffic with biased address collisions.
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] rd, rs1, rs2;
         rd  = AW'($urandom_range(0, 31));
         rs1 = ($urandom_range(0, 3) == 0) ? rd  : AW'($urandom_range(0, 31));
         rs2 = ($urandom_range(0, 3) == 0) ? rs1 : AW'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), rd, rs1, rs2, $urandom);
         #1;
         check_all($sformatf("rnd%0d", i));
         cycle();
      end

      // Asynchronous reset mid-cycle after writing x3.
      drive(1'b1, 5'd3, 5'd0, 5'd0, 32'h11);
      cycle();
      drive(1'b0, '0, 5'd3, 5'd3, '0);
      #1;
      check("x3_written", rf_b.o_REG_OUT1, 32'h11);
      #2;
      irst_n = 1'b0;
      model_reset();
      #1;
      check_ready("async_rst", 1'b0);
      check("async_rst_cnt", rf_b.o_WR_CNT, 32'h0);
      check("async_rst_out1", rf_b.o_REG_OUT1, 32'h0);
      check("async_rst_out2", rf_n.o_REG_OUT2, 32'h0);

      // Writes attempted during reset and CLEAR must be ignored.
      drive(1'b1, 5'd9, 5'd9, 5'd3, 32'hCAFE0009);
      cycle();
      cycle();
      #1;
      irst_n = 1'b1;
      for (int n = 1; n <= 31; n++) begin
         cycle();
         check_ready($sformatf("clr2_edge%0d", n), (n >= 31));
         if (n < 31) check_all($sformatf("clr2_e%0d", n));
      end
      drive(1'b0, '0, 5'd9, 5'd3, '0);
      #1;
      check("x9_after_clear", rf_b.o_REG_OUT1, 32'h0);
      check("x3_after_clear", rf_b.o_REG_OUT2, 32'h0);
      check("x9_after_clear_nob", rf_n.o_REG_OUT1, 32'h0);
      check("cnt_after_clear", rf_b.o_WR_CNT, 32'h0);
      check_all("post_clear");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width (2^ADDR_W registers, x0..x31).
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-004 Port iCLK, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port iRST_N, input, 1: reset, asynchronous and active-low.
REQ-006 Port i_WE, input, 1: write enable for the current cycle.
REQ-007 Port i_RD, input, ADDR_W: destination register index, driven by the operand mux stage.
REQ-008 Port i_RS1, input, ADDR_W: source register 1 index.
REQ-009 Port i_RS2, input, ADDR_W: source register 2 index.
REQ-010 Port i_REG_IN, input, DATA_W: write data.
REQ-011 Port o_REG_OUT1, output, DATA_W: read data for i_RS1.
REQ-012 Port o_REG_OUT2, output, DATA_W: read data for i_RS2.
REQ-013 Port o_READY, output, 1: high once the post-reset clear sequence is complete.
REQ-014 Port o_WR_CNT, output, 32: count of committed register writes.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, a clear index SHALL write zero to one register per rising edge, in order x1, x2, ... x31.
REQ-017 On the edge that clears x31, the FSM SHALL move to RUN, and o_READY SHALL be 1 from that edge onward.
REQ-018 In CLEAR, i_WE SHALL be ignored, o_REG_OUT1/2 SHALL read 0, and o_WR_CNT SHALL not change.
REQ-019 In RUN, a write SHALL commit on the rising edge when i_WE=1 and i_RD!=0; the commit writes i_REG_IN into register i_RD.
REQ-020 A write with i_RD=0 SHALL be discarded and SHALL NOT increment o_WR_CNT.
REQ-021 Register x0 SHALL always read 0, whether or not forwarding conditions are met.
REQ-022 Reads SHALL be combinational with 0-cycle latency: o_REG_OUTn = reg[i_RSn].
REQ-023 With BYPASS=1, if i_WE=1, i_RD=i_RSn, i_RSn!=0 and the FSM is in RUN, then o_REG_OUTn SHALL equal i_REG_IN in that same cycle.
REQ-024 With BYPASS=0, o_REG_OUTn SHALL return the pre-write register value until the following cycle.
REQ-025 If i_RS1=i_RS2, both outputs SHALL carry identical values, including under forwarding.
REQ-026 o_WR_CNT SHALL increment by 1 on each committed write and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 A write to a register in the same cycle as a read of it SHALL commit the new value; the read is resolved as specified in REQ-023/REQ-024.

Reset
REQ-028 While iRST_N=0, the block SHALL asynchronously force: FSM=CLEAR, clear index=1, o_READY=0, o_WR_CNT=0.
REQ-029 While iRST_N=0, o_REG_OUT1/2 SHALL read 0.
REQ-030 Register array contents need not be reset asynchronously; the CLEAR sequence zeroes them.
REQ-031 Reset asserted mid-CLEAR or in RUN SHALL restart the full CLEAR sequence from x1.
REQ-032 The first clear write SHALL occur on the first rising edge after iRST_N deasserts.
REQ-033 o_READY SHALL rise after exactly 31 rising edges following reset deassertion.

Verification
REQ-034 Bench: release reset, count edges -> o_READY=0 for edges 1..30 and 1 after edge 31; then reads of all 32 registers return 0.
REQ-035 Bench: in RUN, write x5=0xDEADBEEF; next cycle set i_RS1=5, i_RS2=0 -> o_REG_OUT1=0xDEADBEEF, o_REG_OUT2=0, o_WR_CNT=1.
REQ-036 Bench: write x0=0x12345678 -> x0 reads 0, o_WR_CNT unchanged.
REQ-037 Bench: BYPASS=1, i_WE=1, i_RD=7, i_REG_IN=0xA5A5A5A5, i_RS1=i_RS2=7 with x7=0 -> both outputs 0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> both outputs 0 that cycle and 0xA5A5A5A5 next cycle.
REQ-038 Bench: write x3=0x11, then assert iRST_N=0 asynchronously mid-cycle -> o_READY=0 and o_WR_CNT=0 immediately; after 31 edges, x3 reads 0.
REQ-039 Bench: assert i_WE=1 with i_RD=9 during CLEAR -> no commit, x9 reads 0 after o_READY=1, o_WR_CNT=0.
